seq_bin_to_bcd: RTL

- Iterative (shift-and-add-3) binary-to-BCD converter, parametrised in input width and output digit count.
- Feeds the VGA score/number display path: the unsigned guess or count goes in, packed BCD digits come out for the digit-glyph lookup.
- Handles the full input range with a tens/ones/... split per digit.
- Valid/ready handshake on both sides; reports overflow when DIGITS is too small for the input value.

---
 rtl/seq_bin_to_bcd_pkg.sv | 22 ++
 rtl/bcd_add3_digit.sv | 15 +
 rtl/seq_bin_to_bcd.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seq_bin_to_bcd_pkg.sv
// rtl/seq_bin_to_bcd_pkg.sv - shared types and sizing helpers for the binary-to-BCD converter
package seq_bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Digits needed to hold any bin_w-bit value: ceil(bin_w * log10(2)).
    // bin_w * log10(2) is never an integer for bin_w > 0, so the rounding
    // constant cannot push an exact result up by one.
    function automatic int min_digits(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

    // Iteration counter width: clog2(bin_w), never less than one bit.
    function automatic int cnt_width(input int bin_w);
        return (bin_w <= 2) ? 1 : $clog2(bin_w);
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// rtl/bcd_add3_digit.sv - double-dabble add-3 correction for one BCD digit
//
// Ports:
//   digit     - working BCD digit before the shift
//   corrected - digit + 3 when digit >= 5, otherwise digit unchanged
module bcd_add3_digit (
    input  logic [3:0] digit,
    output logic [3:0] corrected
);

    // Results 8..12 are intentional: bit 3 becomes the carry into the next
    // digit (or the overflow flag for the top digit) once the register shifts.
    assign corrected = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/seq_bin_to_bcd.sv
// rtl/seq_bin_to_bcd.sv - iterative shift-and-add-3 binary-to-BCD converter with valid/ready
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready - input handshake; in_ready is high only in IDLE
//   bin_in              - unsigned value captured on accept
//   out_valid/out_ready - result handshake; the result is held until accepted
//   bcd_out             - packed BCD, [3:0] ones, [7:4] tens, ...; value mod 10^DIGITS
//   overflow            - the value did not fit in DIGITS digits
//   busy                - a conversion is in progress or awaiting acceptance
module seq_bin_to_bcd
    import seq_bin_to_bcd_pkg::*;
#(
    parameter int BIN_W  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  busy
);

    localparam int CNT_W = cnt_width(BIN_W);
    localparam int BCD_W = 4 * DIGITS;

    state_t             state;
    state_t             state_nxt;
    logic [BIN_W-1:0]   bin_sh;
    logic [BCD_W-1:0]   bcd_work;
    logic [BCD_W-1:0]   bcd_adj;
    logic               ovf_acc;
    logic [CNT_W-1:0]   cnt;

    // One iteration: corrected digits and the binary remainder shift left as
    // a single register; the bit leaving the top digit is lost from bcd_work
    // and remembered only as overflow.
    logic [BCD_W+BIN_W:0] shifted;
    logic [BCD_W-1:0]     work_nxt;
    logic [BIN_W-1:0]     bin_nxt;
    logic                 shift_out;
    logic                 last_iter;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit     (bcd_work[4*i +: 4]),
            .corrected (bcd_adj[4*i +: 4])
        );
    end

    assign shifted   = {bcd_adj, bin_sh, 1'b0};
    assign shift_out = shifted[BCD_W+BIN_W];
    assign work_nxt  = shifted[BCD_W+BIN_W-1:BIN_W];
    assign bin_nxt   = shifted[BIN_W-1:0];
    assign last_iter = (cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sh   <= '0;
            bcd_work <= '0;
            ovf_acc  <= 1'b0;
            cnt      <= '0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sh   <= bin_in;
                        bcd_work <= '0;
                        ovf_acc  <= 1'b0;
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    bin_sh   <= bin_nxt;
                    bcd_work <= work_nxt;
                    ovf_acc  <= ovf_acc | shift_out;
                    cnt      <= cnt + 1'b1;
                    // Outputs update only here so the consumer never sees
                    // a partially converted value.
                    if (last_iter) begin
                        bcd_out  <= work_nxt;
                        overflow <= ovf_acc | shift_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
